// File: rtl/xif_issue_tracker.sv
// xif_issue_tracker
//
// Tracks up to DEPTH offloaded coprocessor instructions between issue, commit and
// result. Coprocessor results are buffered in an in-order FIFO and are released to
// the core only once the owning instruction has been committed. Results of killed
// instructions are dropped, and accepted instructions without writeback free their
// entry at commit/kill time. The issue and commit channels are only snooped.
//
// Ports
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   issue_*_i                      snooped issue handshake and response
//   issue_stall_o                  all tracker entries in use
//   commit_valid_i/id_i/kill_i     commit or kill strobe
//   cop_result_*                   result channel from the coprocessor (FIFO input)
//   core_result_*                  result channel towards the core (FIFO head)
//   outstanding_o                  number of occupied tracker entries
//   err_o                          registered one-cycle pulse on a protocol violation

module xif_issue_tracker #(
   parameter int unsigned  ID_WIDTH   = 4,
   parameter int unsigned  DEPTH      = 4,
   parameter int unsigned  DATA_WIDTH = 32,
   localparam int unsigned CNT_W      = $clog2(DEPTH + 1)
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   // Issue snoop
   input  logic                  issue_valid_i,
   input  logic                  issue_ready_i,
   input  logic                  issue_accept_i,
   input  logic                  issue_writeback_i,
   input  logic [ID_WIDTH-1:0]   issue_id_i,
   output logic                  issue_stall_o,
   // Commit snoop
   input  logic                  commit_valid_i,
   input  logic [ID_WIDTH-1:0]   commit_id_i,
   input  logic                  commit_kill_i,
   // Coprocessor result in
   input  logic                  cop_result_valid_i,
   output logic                  cop_result_ready_o,
   input  logic [ID_WIDTH-1:0]   cop_result_id_i,
   input  logic [DATA_WIDTH-1:0] cop_result_data_i,
   input  logic [4:0]            cop_result_rd_i,
   input  logic                  cop_result_we_i,
   // Result out to core
   output logic                  core_result_valid_o,
   input  logic                  core_result_ready_i,
   output logic [ID_WIDTH-1:0]   core_result_id_o,
   output logic [DATA_WIDTH-1:0] core_result_data_o,
   output logic [4:0]            core_result_rd_o,
   output logic                  core_result_we_o,
   // Status
   output logic [CNT_W-1:0]      outstanding_o,
   output logic                  err_o
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {
      StFree,
      StIssued,
      StCommitted,
      StKilled
   } entry_st_e;

   // Tracker entries
   entry_st_e           state_q [DEPTH];
   entry_st_e           state_d [DEPTH];
   logic [ID_WIDTH-1:0] id_q    [DEPTH];
   logic [ID_WIDTH-1:0] id_d    [DEPTH];
   logic [DEPTH-1:0]    wb_q, wb_d;
   logic                err_q, err_d;

   // Result FIFO storage (no reset needed: occupancy is tracked by fifo_cnt_q)
   logic [ID_WIDTH-1:0]   fifo_id_q   [DEPTH];
   logic [DATA_WIDTH-1:0] fifo_data_q [DEPTH];
   logic [4:0]            fifo_rd_q   [DEPTH];
   logic [DEPTH-1:0]      fifo_we_q;
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]      fifo_cnt_q, fifo_cnt_d;

   logic                fifo_full, fifo_empty;
   logic                push, pop;
   logic [ID_WIDTH-1:0] head_id;

   // Lookup results
   logic             head_hit;
   logic [PTR_W-1:0] head_idx;
   logic             cmt_hit;
   logic [PTR_W-1:0] cmt_idx;
   logic             dup_hit;
   logic             free_found;
   logic [PTR_W-1:0] alloc_idx;
   logic [CNT_W-1:0] occ;
   logic             issue_fire;
   logic             head_valid;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign fifo_full  = (fifo_cnt_q == CNT_W'(DEPTH));
   assign fifo_empty = (fifo_cnt_q == '0);
   assign head_id    = fifo_id_q[rd_ptr_q];
   // Ready depends on registered occupancy only, never on a same-cycle pop.
   assign push       = cop_result_valid_i & ~fifo_full;
   assign issue_fire = issue_valid_i & issue_ready_i & issue_accept_i;

   //---------------------------------------------------------------------------
   // Tracker lookups, all against registered state
   //---------------------------------------------------------------------------
   always_comb begin
      head_hit   = 1'b0;
      head_idx   = '0;
      cmt_hit    = 1'b0;
      cmt_idx    = '0;
      dup_hit    = 1'b0;
      free_found = 1'b0;
      alloc_idx  = '0;
      occ        = '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         if (state_q[i] != StFree) begin
            occ = occ + CNT_W'(1);
            if (id_q[i] == issue_id_i) begin
               dup_hit = 1'b1;
            end
            // Only entries expecting a writeback can own a buffered result.
            if (wb_q[i] && (id_q[i] == head_id)) begin
               head_hit = 1'b1;
               head_idx = PTR_W'(i);
            end
         end
         if ((state_q[i] == StIssued) && (id_q[i] == commit_id_i)) begin
            cmt_hit = 1'b1;
            cmt_idx = PTR_W'(i);
         end
      end
      // Descending scan so the lowest free index wins.
      for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
         if (state_q[i] == StFree) begin
            free_found = 1'b1;
            alloc_idx  = PTR_W'(i);
         end
      end
   end

   //---------------------------------------------------------------------------
   // Next-state logic
   //---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      id_d    = id_q;
      wb_d    = wb_q;
      err_d   = 1'b0;
      pop     = 1'b0;

      // Head stage. Only frees COMMITTED/KILLED entries, so it never collides with
      // the commit path (ISSUED only) or allocation (FREE only).
      if (!fifo_empty) begin
         if (!head_hit) begin
            pop   = 1'b1;
            err_d = 1'b1;
         end else begin
            case (state_q[head_idx])
               StCommitted: begin
                  if (core_result_ready_i) begin
                     pop               = 1'b1;
                     state_d[head_idx] = StFree;
                  end
               end
               StKilled: begin
                  pop               = 1'b1;
                  state_d[head_idx] = StFree;
               end
               default: ;
            endcase
         end
      end

      if (commit_valid_i) begin
         if (!cmt_hit) begin
            err_d = 1'b1;
         end else if (!wb_q[cmt_idx]) begin
            state_d[cmt_idx] = StFree;
         end else begin
            state_d[cmt_idx] = commit_kill_i ? StKilled : StCommitted;
         end
      end

      // Allocation only considers entries free in registered state, so an entry
      // released this cycle becomes reusable next cycle.
      if (issue_fire) begin
         if (dup_hit || !free_found) begin
            err_d = 1'b1;
         end else begin
            state_d[alloc_idx] = StIssued;
            id_d[alloc_idx]    = issue_id_i;
            wb_d[alloc_idx]    = issue_writeback_i;
         end
      end
   end

   always_comb begin
      wr_ptr_d   = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d   = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      fifo_cnt_d = fifo_cnt_q;
      case ({push, pop})
         2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
         2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
         default: ;
      endcase
   end

   //---------------------------------------------------------------------------
   // State registers
   //---------------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            state_q[i] <= StFree;
            id_q[i]    <= '0;
         end
         wb_q       <= '0;
         err_q      <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         fifo_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         id_q       <= id_d;
         wb_q       <= wb_d;
         err_q      <= err_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         fifo_cnt_q <= fifo_cnt_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) begin
         fifo_id_q[wr_ptr_q]   <= cop_result_id_i;
         fifo_data_q[wr_ptr_q] <= cop_result_data_i;
         fifo_rd_q[wr_ptr_q]   <= cop_result_rd_i;
         fifo_we_q[wr_ptr_q]   <= cop_result_we_i;
      end
   end

   //---------------------------------------------------------------------------
   // Outputs (registered state only)
   //---------------------------------------------------------------------------
   always_comb begin
      head_valid          = ~fifo_empty & head_hit & (state_q[head_idx] == StCommitted);
      core_result_valid_o = head_valid;
      // Data outputs read zero whenever nothing is presented.
      core_result_id_o    = '0;
      core_result_data_o  = '0;
      core_result_rd_o    = '0;
      core_result_we_o    = 1'b0;
      if (head_valid) begin
         core_result_id_o   = head_id;
         core_result_data_o = fifo_data_q[rd_ptr_q];
         core_result_rd_o   = fifo_rd_q[rd_ptr_q];
         core_result_we_o   = fifo_we_q[rd_ptr_q];
      end
      issue_stall_o      = (occ == CNT_W'(DEPTH));
      outstanding_o      = occ;
      cop_result_ready_o = ~fifo_full;
      err_o              = err_q;
   end

endmodule

// File: tb/tb_xif_issue_tracker.sv
module tb_xif_issue_tracker;

   localparam int unsigned IdW    = 4;
   localparam int unsigned Depth  = 4;
   localparam int unsigned DataW  = 32;
   localparam int unsigned NumIds = 1 << IdW;
   localparam int unsigned CntW   = $clog2(Depth + 1);

   localparam int MFree      = 0;
   localparam int MIssued    = 1;
   localparam int MCommitted = 2;
   localparam int MKilled    = 3;

   logic             clk_i = 1'b0;
   logic             rst_ni;
   logic             issue_valid_i, issue_ready_i, issue_accept_i, issue_writeback_i;
   logic [IdW-1:0]   issue_id_i;
   logic             issue_stall_o;
   logic             commit_valid_i, commit_kill_i;
   logic [IdW-1:0]   commit_id_i;
   logic             cop_result_valid_i, cop_result_ready_o;
   logic [IdW-1:0]   cop_result_id_i;
   logic [DataW-1:0] cop_result_data_i;
   logic [4:0]       cop_result_rd_i;
   logic             cop_result_we_i;
   logic             core_result_valid_o, core_result_ready_i;
   logic [IdW-1:0]   core_result_id_o;
   logic [DataW-1:0] core_result_data_o;
   logic [4:0]       core_result_rd_o;
   logic             core_result_we_o;
   logic [CntW-1:0]  outstanding_o;
   logic             err_o;

   xif_issue_tracker #(
      .ID_WIDTH  (IdW),
      .DEPTH     (Depth),
      .DATA_WIDTH(DataW)
   ) u_dut (
      .clk_i              (clk_i),
      .rst_ni             (rst_ni),
      .issue_valid_i      (issue_valid_i),
      .issue_ready_i      (issue_ready_i),
      .issue_accept_i     (issue_accept_i),
      .issue_writeback_i  (issue_writeback_i),
      .issue_id_i         (issue_id_i),
      .issue_stall_o      (issue_stall_o),
      .commit_valid_i     (commit_valid_i),
      .commit_id_i        (commit_id_i),
      .commit_kill_i      (commit_kill_i),
      .cop_result_valid_i (cop_result_valid_i),
      .cop_result_ready_o (cop_result_ready_o),
      .cop_result_id_i    (cop_result_id_i),
      .cop_result_data_i  (cop_result_data_i),
      .cop_result_rd_i    (cop_result_rd_i),
      .cop_result_we_i    (cop_result_we_i),
      .core_result_valid_o(core_result_valid_o),
      .core_result_ready_i(core_result_ready_i),
      .core_result_id_o   (core_result_id_o),
      .core_result_data_o (core_result_data_o),
      .core_result_rd_o   (core_result_rd_o),
      .core_result_we_o   (core_result_we_o),
      .outstanding_o      (outstanding_o),
      .err_o              (err_o)
   );

   always #5 clk_i = ~clk_i;

   // Reference model: per-id instruction status plus an in-order result queue.
   typedef struct packed {
      logic [IdW-1:0]   id;
      logic [DataW-1:0] data;
      logic [4:0]       rd;
      logic             we;
   } res_t;

   int   m_st [NumIds];
   bit   m_wb [NumIds];
   res_t m_q[$];
   bit   m_err;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic int m_occ();
      int n = 0;
      for (int i = 0; i < int'(NumIds); i++) if (m_st[i] != MFree) n++;
      return n;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < int'(NumIds); i++) begin
         m_st[i] = MFree;
         m_wb[i] = 1'b0;
      end
      m_q.delete();
      m_err = 1'b0;
   endtask

   // Advance the model by one clock using the inputs currently driven.
   task automatic model_step();
      bit   e      = 1'b0;
      int   pre_n  = m_occ();
      int   pre_qn = m_q.size();
      bit   fire   = issue_valid_i && issue_ready_i && issue_accept_i;
      bit   dup    = fire && (m_st[issue_id_i] != MFree);
      res_t h;
      res_t r;
      if (pre_qn > 0) begin
         h = m_q[0];
         if (m_st[h.id] == MFree || !m_wb[h.id]) begin
            void'(m_q.pop_front());
            e = 1'b1;
         end else if (m_st[h.id] == MKilled) begin
            void'(m_q.pop_front());
            m_st[h.id] = MFree;
         end else if (m_st[h.id] == MCommitted && core_result_ready_i) begin
            void'(m_q.pop_front());
            m_st[h.id] = MFree;
         end
      end
      if (commit_valid_i) begin
         if (m_st[commit_id_i] != MIssued) e = 1'b1;
         else if (!m_wb[commit_id_i]) m_st[commit_id_i] = MFree;
         else m_st[commit_id_i] = commit_kill_i ? MKilled : MCommitted;
      end
      if (fire) begin
         if (dup || pre_n >= int'(Depth)) begin
            e = 1'b1;
         end else begin
            m_st[issue_id_i] = MIssued;
            m_wb[issue_id_i] = issue_writeback_i;
         end
      end
      if (cop_result_valid_i && pre_qn < int'(Depth)) begin
         r.id   = cop_result_id_i;
         r.data = cop_result_data_i;
         r.rd   = cop_result_rd_i;
         r.we   = cop_result_we_i;
         m_q.push_back(r);
      end
      m_err = e;
   endtask

   task automatic compare_outputs();
      int   n  = m_occ();
      bit   hv = 1'b0;
      res_t h;
      check_eq("outstanding", 64'(outstanding_o), 64'(n));
      check_eq("stall", 64'(issue_stall_o), 64'(n == int'(Depth)));
      check_eq("cop_ready", 64'(cop_result_ready_o), 64'(m_q.size() < int'(Depth)));
      check_eq("err", 64'(err_o), 64'(m_err));
      if (m_q.size() > 0) begin
         h  = m_q[0];
         hv = (m_st[h.id] == MCommitted) && m_wb[h.id];
      end
      check_eq("core_valid", 64'(core_result_valid_o), 64'(hv));
      if (hv) begin
         check_eq("core_id", 64'(core_result_id_o), 64'(h.id));
         check_eq("core_data", 64'(core_result_data_o), 64'(h.data));
         check_eq("core_rd", 64'(core_result_rd_o), 64'(h.rd));
         check_eq("core_we", 64'(core_result_we_o), 64'(h.we));
      end
   endtask

   // One clock: check outputs mid-cycle, step the model, return just after the edge.
   task automatic cycle();
      @(negedge clk_i);
      compare_outputs();
      model_step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic clr();
      issue_valid_i       = 1'b0;
      issue_ready_i       = 1'b1;
      issue_accept_i      = 1'b1;
      issue_writeback_i   = 1'b1;
      issue_id_i          = '0;
      commit_valid_i      = 1'b0;
      commit_id_i         = '0;
      commit_kill_i       = 1'b0;
      cop_result_valid_i  = 1'b0;
      cop_result_id_i     = '0;
      cop_result_data_i   = '0;
      cop_result_rd_i     = '0;
      cop_result_we_i     = 1'b0;
      core_result_ready_i = 1'b1;
   endtask

   task automatic idle();
      clr();
      cycle();
   endtask

   task automatic do_issue(input int id, input bit wb);
      clr();
      issue_valid_i     = 1'b1;
      issue_id_i        = IdW'(id);
      issue_writeback_i = wb;
      cycle();
   endtask

   task automatic do_commit(input int id, input bit kill);
      clr();
      commit_valid_i = 1'b1;
      commit_id_i    = IdW'(id);
      commit_kill_i  = kill;
      cycle();
   endtask

   task automatic do_result(input int id, input logic [DataW-1:0] d, input int rd, input bit crdy);
      clr();
      cop_result_valid_i  = 1'b1;
      cop_result_id_i     = IdW'(id);
      cop_result_data_i   = d;
      cop_result_rd_i     = 5'(rd);
      cop_result_we_i     = 1'b1;
      core_result_ready_i = crdy;
      cycle();
   endtask

   // Mostly an id in the wanted status (want < 0: any live id), sometimes random.
   function automatic logic [IdW-1:0] pick_id(input int want, input bit need_wb);
      int c[$];
      for (int i = 0; i < int'(NumIds); i++) begin
         if (((want < 0 && m_st[i] != MFree) || m_st[i] == want) && (!need_wb || m_wb[i]))
            c.push_back(i);
      end
      if (c.size() == 0 || $urandom_range(0, 7) == 0) return IdW'($urandom_range(0, NumIds - 1));
      return IdW'(c[$urandom_range(0, c.size() - 1)]);
   endfunction

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_outstanding"}, 64'(outstanding_o), 64'd0);
      check_eq({tag, "_stall"}, 64'(issue_stall_o), 64'd0);
      check_eq({tag, "_cop_ready"}, 64'(cop_result_ready_o), 64'd1);
      check_eq({tag, "_valid"}, 64'(core_result_valid_o), 64'd0);
      check_eq({tag, "_id"}, 64'(core_result_id_o), 64'd0);
      check_eq({tag, "_data"}, 64'(core_result_data_o), 64'd0);
      check_eq({tag, "_rd"}, 64'(core_result_rd_o), 64'd0);
      check_eq({tag, "_we"}, 64'(core_result_we_o), 64'd0);
      check_eq({tag, "_err"}, 64'(err_o), 64'd0);
   endtask

   initial begin
      clr();
      model_reset();
      rst_ni = 1'b0;
      repeat (2) @(posedge clk_i);
      #1;
      check_reset_outputs("reset");
      @(negedge clk_i);
      rst_ni = 1'b1;
      @(posedge clk_i);
      #1;

      // Basic flow
      do_issue(3, 1'b1);
      do_commit(3, 1'b0);
      do_result(3, 32'hDEAD_BEEF, 7, 1'b1);
      check_eq("basic_valid", 64'(core_result_valid_o), 64'd1);
      check_eq("basic_id", 64'(core_result_id_o), 64'd3);
      check_eq("basic_data", 64'(core_result_data_o), 64'hDEAD_BEEF);
      check_eq("basic_rd", 64'(core_result_rd_o), 64'd7);
      idle();
      check_eq("basic_drain", 64'(outstanding_o), 64'd0);

      // Result before commit
      do_issue(1, 1'b1);
      do_result(1, 32'h1234_5678, 2, 1'b1);
      for (int i = 0; i < 5; i++) begin
         check_eq("rbc_hold", 64'(core_result_valid_o), 64'd0);
         idle();
      end
      do_commit(1, 1'b0);
      check_eq("rbc_rise", 64'(core_result_valid_o), 64'd1);
      idle();

      // Kill
      do_issue(0, 1'b1);
      do_issue(1, 1'b1);
      do_commit(0, 1'b1);
      do_commit(1, 1'b0);
      do_result(0, 32'h0000_AAAA, 3, 1'b1);
      check_eq("kill_drop_cycle", 64'(core_result_valid_o), 64'd0);
      do_result(1, 32'h0000_BBBB, 4, 1'b1);
      check_eq("kill_valid", 64'(core_result_valid_o), 64'd1);
      check_eq("kill_id", 64'(core_result_id_o), 64'd1);
      check_eq("kill_data", 64'(core_result_data_o), 64'h0000_BBBB);
      check_eq("kill_err", 64'(err_o), 64'd0);
      idle();
      check_eq("kill_drain", 64'(outstanding_o), 64'd0);

      // Full
      for (int i = 0; i < int'(Depth); i++) do_issue(i, 1'b0);
      check_eq("full_stall", 64'(issue_stall_o), 64'd1);
      check_eq("full_count", 64'(outstanding_o), 64'(Depth));
      do_commit(2, 1'b0);
      check_eq("full_unstall", 64'(issue_stall_o), 64'd0);
      check_eq("full_count3", 64'(outstanding_o), 64'd3);
      do_commit(0, 1'b0);
      do_commit(1, 1'b0);
      do_commit(3, 1'b0);
      check_eq("full_drain", 64'(outstanding_o), 64'd0);

      // Errors
      do_commit(9, 1'b0);
      check_eq("err_unknown", 64'(err_o), 64'd1);
      idle();
      check_eq("err_clear", 64'(err_o), 64'd0);
      do_issue(0, 1'b0);
      do_issue(0, 1'b0);
      check_eq("err_dup", 64'(err_o), 64'd1);
      check_eq("err_dup_count", 64'(outstanding_o), 64'd1);
      do_commit(0, 1'b0);
      do_result(5, 32'h55, 5, 1'b1);
      check_eq("err_orphan_pre", 64'(err_o), 64'd0);
      idle();
      check_eq("err_orphan", 64'(err_o), 64'd1);
      idle();
      check_eq("err_state", 64'(outstanding_o), 64'd0);

      // Reset with buffered results
      do_issue(1, 1'b1);
      do_issue(2, 1'b1);
      do_commit(1, 1'b0);
      do_result(1, 32'h11, 1, 1'b0);
      do_result(2, 32'h22, 2, 1'b0);
      clr();
      core_result_ready_i = 1'b0;
      check_eq("prerst_valid", 64'(core_result_valid_o), 64'd1);
      check_eq("prerst_ready", 64'(cop_result_ready_o), 64'd1);
      #2;
      rst_ni = 1'b0;
      #1;
      check_reset_outputs("midrst");
      model_reset();
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      rst_ni = 1'b1;
      @(posedge clk_i);
      #1;
      do_issue(4, 1'b1);
      do_commit(4, 1'b0);
      do_result(4, 32'hCAFE, 9, 1'b1);
      check_eq("postrst_valid", 64'(core_result_valid_o), 64'd1);
      check_eq("postrst_data", 64'(core_result_data_o), 64'hCAFE);
      idle();
      check_eq("postrst_drain", 64'(outstanding_o), 64'd0);

      // Randomized traffic against the model
      for (int n = 0; n < 3000; n++) begin
         clr();
         if (m_occ() < int'(Depth) && $urandom_range(0, 2) == 0) begin
            issue_valid_i     = 1'b1;
            issue_ready_i     = ($urandom_range(0, 3) != 0);
            issue_accept_i    = ($urandom_range(0, 3) != 0);
            issue_writeback_i = ($urandom_range(0, 3) != 0);
            issue_id_i        = IdW'($urandom_range(0, NumIds - 1));
         end
         if ($urandom_range(0, 2) == 0) begin
            commit_valid_i = 1'b1;
            commit_id_i    = pick_id(MIssued, 1'b0);
            commit_kill_i  = ($urandom_range(0, 3) == 0);
         end
         if ($urandom_range(0, 1) == 0) begin
            cop_result_valid_i = 1'b1;
            cop_result_id_i    = pick_id(-1, 1'b1);
            cop_result_data_i  = $urandom;
            cop_result_rd_i    = 5'($urandom_range(0, 31));
            cop_result_we_i    = 1'($urandom_range(0, 1));
         end
         core_result_ready_i = ($urandom_range(0, 3) != 0);
         cycle();
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/xif_issue_tracker.md
# xif_issue_tracker

Sequential companion to the CV-X-IF bridge in `core-v-mini-mcu`. It tracks up to `DEPTH` offloaded coprocessor instructions between issue, commit and result. It buffers coprocessor results until the core has committed the instruction. It silently drops results of killed instructions and releases entries for accepted instructions that produce no writeback. It sits between the core-side X-IF signals and the coprocessor result channel, and snoops the issue and commit channels without driving them.

## Interface
Parameters:
- `ID_WIDTH`, 4: width of the instruction id.
- `DEPTH`, 4: maximum outstanding instructions; also the result FIFO depth; 2..2**ID_WIDTH.
- `DATA_WIDTH`, 32: result data width.
- `CNT_W`, `$clog2(DEPTH+1)`: derived, not overridable.

Ports:
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `issue_valid_i` / `issue_ready_i` in 1/1: snooped issue handshake.
- `issue_accept_i` / `issue_writeback_i` in 1/1: snooped issue response.
- `issue_id_i` in ID_WIDTH: id being issued.
- `issue_stall_o` out 1: all entries in use; core must hold `issue_valid`.
- `commit_valid_i` in 1: commit strobe.
- `commit_id_i` in ID_WIDTH: id being committed.
- `commit_kill_i` in 1: kill instead of commit.
- `cop_result_valid_i` / `cop_result_ready_o` in 1/out 1: coprocessor result handshake.
- `cop_result_id_i` in ID_WIDTH; `cop_result_data_i` in DATA_WIDTH; `cop_result_rd_i` in 5; `cop_result_we_i` in 1.
- `core_result_valid_o` / `core_result_ready_i` out 1/in 1: result handshake towards the core.
- `core_result_id_o` out ID_WIDTH; `core_result_data_o` out DATA_WIDTH; `core_result_rd_o` out 5; `core_result_we_o` out 1.
- `outstanding_o` out CNT_W: number of occupied tracker entries.
- `err_o` out 1: one-cycle pulse on any protocol violation.

## Operation
- **Tracker.** `DEPTH` entries. Each entry holds {state, id, wb}. State is one of FREE, ISSUED, COMMITTED, KILLED.
- **Allocate.** On `issue_valid_i & issue_ready_i & issue_accept_i`, the lowest-index FREE entry goes to ISSUED and stores id and wb.
  - Rejected issue (`accept=0`): no allocation.
  - If the id is already live in a non-FREE entry: no allocation, `err_o` pulses.
- **Commit.** On `commit_valid_i`, find the ISSUED entry matching `commit_id_i`.
  - Kill: entry goes to KILLED. If wb=0, it goes straight to FREE.
  - Commit: entry goes to COMMITTED. If wb=0, it goes straight to FREE.
  - No matching ISSUED entry: `err_o` pulses, no state change.
- **Result in.** `cop_result_ready_o = !fifo_full`. On handshake, {id, data, rd, we} is pushed into the FIFO.
  - No live entry with wb=1 matches the id: the push still happens, and `err_o` pulses at the head stage.
- **Head stage.** Looks up the tracker entry for the FIFO head id.
  - COMMITTED: `core_result_valid_o=1` with the head fields. On `core_result_ready_i`, pop and set the entry to FREE.
  - KILLED: pop with no output and set the entry to FREE. Takes one cycle, and `core_result_valid_o` stays 0 in that cycle.
  - ISSUED: hold; `core_result_valid_o=0`. Results leave strictly in arrival order.
  - No matching entry: pop, drop, pulse `err_o`.
- **Counters.** `issue_stall_o = (outstanding_o == DEPTH)`. `outstanding_o` counts non-FREE entries and never exceeds DEPTH.

## Timing
- **Reset values.** All entries FREE, FIFO empty, `outstanding_o=0`, `issue_stall_o=0`, `cop_result_ready_o=1`, `core_result_valid_o=0`, `core_result_*` data outputs = 0, `err_o=0`.
- **Reset mid-operation.** Discards all entries and buffered results immediately (asynchronous).
- **Latency.** FIFO is registered. A result pushed in cycle N can be presented at the earliest in cycle N+1, provided its entry is COMMITTED by the end of cycle N.
- **Same-cycle events.**
  - Allocate and free in the same cycle: the net count updates correctly. A freed entry is not reusable until the next cycle.
  - A commit for the head id in the same cycle as the head lookup takes effect in the next cycle.
  - Full FIFO with push and pop in the same cycle: push accepted only if `fifo_full` was 0 at the start of the cycle (ready does not depend on pop).
- **Outputs.** `issue_stall_o` and `core_result_valid_o` derive from registered state only, with no combinational path from `*_valid_i`. `cop_result_ready_o` is registered-state only.
- **Output stability.** `core_result_*` outputs stay stable while `valid=1 & ready=0`.
- **Error flag.** `err_o` is registered and asserts the cycle after the violation.

## Test plan
- **Basic flow.** Issue id 3 (accept, wb), commit 3, coprocessor result id 3 data 0xDEADBEEF rd 7 -> core sees valid, id 3, data 0xDEADBEEF, rd 7, one cycle after push; `outstanding_o` returns to 0.
- **Result before commit.** Issue id 1, push result id 1, hold commit 5 cycles -> `core_result_valid_o` stays 0, rises the cycle after commit.
- **Kill.** Issue ids 0 and 1, kill 0, commit 1, results arrive 0 then 1 -> only id 1 reaches the core, one cycle after the drop cycle; `err_o` stays 0.
- **Full.** Issue DEPTH=4 ids 0..3 with wb=0 uncommitted -> `issue_stall_o=1`. Commit id 2 -> stall drops next cycle and `outstanding_o=3`.
- **Errors.** Commit an unknown id 9, issue a duplicate live id 0, push an orphan result id 5 -> `err_o` pulses once for each, and no state is corrupted.
- **Reset.** Assert `rst_ni` with 2 buffered results -> all outputs return to reset values asynchronously; after release, a fresh issue/commit/result works normally.
